// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode/state enums and op classification.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_div_op(op_e o);
    return (o == OP_DIV) || (o == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring iterative divider, one quotient bit per cycle, MSB first.
// done is combinational on the final step; quo_next/rem_next carry that step's values.
module alu_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   trial, diff;
  logic             ge;

  // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
  assign trial    = {rem, quo[WIDTH-1]};
  assign diff     = trial - {1'b0, dvs};
  assign ge       = trial >= {1'b0, dvs};
  assign rem_next = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ge};
  assign busy     = (cnt != '0);
  assign done     = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= CNT_W'(WIDTH);
    end else if (busy) begin
      rem <= rem_next;
      quo <= quo_next;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/mul/logic, iterative div/mod.
// Optional zero/carry/overflow flag outputs when ALU_SEQ_FLAGS_EN is defined.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             overflow
`endif
);

  state_e           state, state_d;
  op_e              op_in, op_q, op_d;
  logic [WIDTH-1:0] result_d;
  logic             dbz_d, accept, div_start;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign op_in     = op_e'(op);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  alu_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .busy     (div_busy),
    .done     (div_done),
    .quo_next (div_quo),
    .rem_next (div_rem)
  );

  always_comb begin
    state_d   = state;
    result_d  = result;
    dbz_d     = div_by_zero;
    op_d      = op_q;
    div_start = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        op_d    = op_in;
        state_d = S_DONE;
        case (op_in)
          OP_ADD: result_d = a + b;
          OP_SUB: result_d = a - b;
          OP_MUL: result_d = a * b;
          OP_AND: result_d = a & b;
          OP_OR:  result_d = a | b;
          OP_XOR: result_d = a ^ b;
          default: begin
            if (b == '0) begin
              result_d = (op_in == OP_DIV) ? '1 : a;
              dbz_d    = 1'b1;
            end else begin
              div_start = 1'b1;
              state_d   = S_DIV;
            end
          end
        endcase
      end
      // !div_busy only guards against a stuck divider; it never fires normally.
      S_DIV: if (div_done || !div_busy) begin
        result_d = (op_q == OP_MOD) ? div_rem : div_quo;
        state_d  = S_DONE;
      end
      S_DONE: if (out_ready) begin
        state_d = S_IDLE;
        dbz_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      result      <= '0;
      div_by_zero <= 1'b0;
      op_q        <= OP_ADD;
    end else begin
      state       <= state_d;
      result      <= result_d;
      div_by_zero <= dbz_d;
      op_q        <= op_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [WIDTH:0] sum_x, diff_x;
  logic           zero_d, carry_d, ovf_d;

  assign sum_x  = {1'b0, a} + {1'b0, b};
  assign diff_x = {1'b0, a} - {1'b0, b};

  // zero follows every result write; carry/overflow only mean something for add/sub.
  always_comb begin
    zero_d  = zero;
    carry_d = carry;
    ovf_d   = overflow;
    if (state_d == S_DONE && state != S_DONE)
      zero_d = (result_d == '0);
    if (accept) begin
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      if (op_in == OP_ADD) begin
        carry_d = sum_x[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_x[WIDTH-1] != a[WIDTH-1]);
      end else if (op_in == OP_SUB) begin
        carry_d = diff_x[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_x[WIDTH-1] != a[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      zero     <= zero_d;
      carry    <= carry_d;
      overflow <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized-handshake checks for alu_seq at WIDTH=32.
// Flag checks are included when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [2:0]  op;
  logic        div_by_zero;
`ifdef ALU_SEQ_FLAGS_EN
  logic        zero, carry, overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .zero        (zero),
    .carry       (carry),
    .overflow    (overflow)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic fz, fc, fo;

  // Issue one request, wait (bounded) for the result, then handshake it.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b, input logic [2:0] top,
                        output logic [31:0] res, output logic dz, output int lat,
                        output logic rdy_seen);
    a = ta; b = tb_b; op = top; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = in_ready;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
      if (in_ready) rdy_seen = 1'b1;
    end
    res = result;
    dz  = div_by_zero;
`ifdef ALU_SEQ_FLAGS_EN
    fz = zero; fc = carry; fo = overflow;
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] r, exp_r, ra, rb;
  logic        dz, rdy, exp_dz, done;
  logic [2:0]  rop;
  int          lat, guard;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    fz = 1'b0; fc = 1'b0; fo = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a division aborts it.
    a = 32'd100; b = 32'd7; op = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("middiv_busy", {31'd0, in_ready}, 32'd0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(32'd2, 32'd3, 3'd0, r, dz, lat, rdy);
    check("add_2_3", r, 32'd5);
    check("add_lat", lat, 32'd1);
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);

    run_op(32'hFFFF_FFFF, 32'd1, 3'd0, r, dz, lat, rdy);
    check("add_wrap", r, 32'd0);
    check("add_wrap_lat", lat, 32'd1);
`ifdef ALU_SEQ_FLAGS_EN
    check("add_wrap_zero", {31'd0, fz}, 32'd1);
    check("add_wrap_carry", {31'd0, fc}, 32'd1);
    check("add_wrap_ovf", {31'd0, fo}, 32'd0);
    run_op(32'h7FFF_FFFF, 32'd1, 3'd0, r, dz, lat, rdy);
    check("add_ovf_res", r, 32'h8000_0000);
    check("add_ovf_flag", {29'd0, fz, fc, fo}, 32'd1);
`endif

    run_op(32'd3, 32'd5, 3'd1, r, dz, lat, rdy);
    check("sub_wrap", r, 32'hFFFF_FFFE);
`ifdef ALU_SEQ_FLAGS_EN
    check("sub_flags", {29'd0, fz, fc, fo}, 32'd2);
`endif

    run_op(32'd100, 32'd7, 3'd3, r, dz, lat, rdy);
    check("div_100_7", r, 32'd14);
    check("div_lat", lat, 32'd33);
    check("div_in_ready_low", {31'd0, rdy}, 32'd0);
    check("div_dbz", {31'd0, dz}, 32'd0);
    run_op(32'd100, 32'd7, 3'd4, r, dz, lat, rdy);
    check("mod_100_7", r, 32'd2);
    check("mod_lat", lat, 32'd33);
    check("mod_in_ready_low", {31'd0, rdy}, 32'd0);

    run_op(32'd55, 32'd0, 3'd3, r, dz, lat, rdy);
    check("div0_res", r, 32'hFFFF_FFFF);
    check("div0_dbz", {31'd0, dz}, 32'd1);
    check("div0_lat", lat, 32'd1);
    check("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
    run_op(32'd55, 32'd0, 3'd4, r, dz, lat, rdy);
    check("mod0_res", r, 32'd55);
    check("mod0_dbz", {31'd0, dz}, 32'd1);

    run_op(32'hFFFF_FFFF, 32'd1, 3'd3, r, dz, lat, rdy);
    check("div_max_by_1", r, 32'hFFFF_FFFF);
    run_op(32'd5, 32'd9, 3'd4, r, dz, lat, rdy);
    check("mod_small", r, 32'd5);
    run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 3'd5, r, dz, lat, rdy);
    check("and", r, 32'h00F0_1234);
    run_op(32'hF0F0_1234, 32'h0FF0_0001, 3'd6, r, dz, lat, rdy);
    check("or", r, 32'hFFF0_1235);
    run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 3'd7, r, dz, lat, rdy);
    check("xor", r, 32'hFF00_EDCB);
    run_op(32'd1234, 32'd5678, 3'd2, r, dz, lat, rdy);
    check("mul_small", r, 32'd7006652);

    // Backpressure: result held, junk requests ignored, exactly one handshake.
    a = 32'h0001_0000; b = 32'h0001_0000; op = 3'd2; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = $urandom; b = $urandom; op = 3'd0;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_result", result, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_single_hs", {30'd0, out_valid, in_ready}, 32'd1);
      tick();
    end

    // Mixed ops with random consumer stalls and junk in_valid while busy.
    for (int k = 0; k < 40; k++) begin
      ra  = $urandom;
      rb  = (k % 4 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      rop = 3'($urandom_range(0, 7));
      exp_dz = 1'b0;
      case (rop)
        3'd0: exp_r = ra + rb;
        3'd1: exp_r = ra - rb;
        3'd2: exp_r = ra * rb;
        3'd3: begin exp_r = (rb == 0) ? 32'hFFFF_FFFF : ra / rb; exp_dz = (rb == 0); end
        3'd4: begin exp_r = (rb == 0) ? ra : ra % rb; exp_dz = (rb == 0); end
        3'd5: exp_r = ra & rb;
        3'd6: exp_r = ra | rb;
        default: exp_r = ra ^ rb;
      endcase
      repeat ($urandom_range(0, 2)) tick();
      a = ra; b = rb; op = rop; in_valid = 1'b1;
      tick();
      done = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
        in_valid  = 1'($urandom_range(0, 1));
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          check("rnd_result", result, exp_r);
          check("rnd_dbz", {31'd0, div_by_zero}, {31'd0, exp_dz});
          done = 1'b1;
        end
        tick();
        guard++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("rnd_completed", {31'd0, done}, 32'd1);
      check("rnd_no_dup", {31'd0, out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
